instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
//  Writer side of the instruction memory debug-write port. Takes the byte stream from the
//  debug UART receiver, packs 4 bytes into a 32-bit instruction and writes it to consecutive
//  instruction-memory addresses starting at 0.
//  Loading stops after the HALT word has been written, or when the memory is full. The top
//  level muxes o_addr onto the memory address input while o_busy=1.
// PARAMETERS
//  ADDR_W     5             word-address width; DEPTH = 2**ADDR_W (32 words)
//  HALT_WORD  32'hFFFF_FFFF end-of-program marker; it is itself written to memory
//  BIG_ENDIAN 1             1: first byte -> bits[31:24]; 0: first byte -> bits[7:0]
// PORTS
//  clk                 in   1   system clock; all state changes on posedge
//  rst                 in   1   asynchronous, active-low reset
//  i_start             in   1   level/pulse; starts a load from IDLE or DONE
//  i_rx_data           in   8   received byte
//  i_rx_valid          in   1   1-cycle strobe; i_rx_data valid this cycle
//  o_wr_instruction    out  1   write strobe to instruction memory (exactly 1 cycle per word)
//  o_addr              out  32  word address, zero-extended from ADDR_W-bit counter
//  o_data_instruction  out  32  assembled instruction word
//  o_busy              out  1   high in LOAD and WRITE states
//  o_done              out  1   high in DONE state
//  o_overflow          out  1   memory filled without HALT_WORD; sticky until next start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; byte counter, word counter and assembly reg cleared.
//  Reset asserted mid-load: same result immediately (async); partial word discarded.
//  All outputs are registered, so they are stable across the negedge on which memory samples.
//  FSM:
//   IDLE  : i_start=1 -> LOAD; word_cnt=0, byte_cnt=0, o_overflow=0. i_rx_valid ignored.
//   LOAD  : each i_rx_valid shifts i_rx_data into the assembly reg per BIG_ENDIAN and
//           increments byte_cnt. On the 4th byte -> WRITE, with o_data_instruction=assembled
//           word, o_addr=word_cnt, o_wr_instruction=1 in the next cycle.
//   WRITE : one cycle; o_wr_instruction=1.
//           word==HALT_WORD           -> DONE.
//           else word_cnt==DEPTH-1    -> DONE, o_overflow=1.
//           else word_cnt+=1          -> LOAD.
//           An i_rx_valid during WRITE is accepted as byte 0 of the next word; it is never
//           dropped. o_data_instruction is a separate register from the assembly reg.
//   DONE  : o_done=1; i_rx_valid ignored; i_start=1 -> LOAD with counters cleared.
//  i_start is ignored in LOAD and WRITE.
//  o_wr_instruction is 0 in every state except WRITE.
//  o_addr and o_data_instruction hold their last values outside WRITE.
//  Back-to-back bytes every cycle are supported: minimum of 4 cycles per word, no stalls.
//  word_cnt never wraps. The write at DEPTH-1 is the last one.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE, LOAD, WRITE, DONE), HALT_WORD default,
//  instruction width (32).
//  Natural sub-module: byte_packer (byte shift/assemble reg + 2-bit byte counter, BIG_ENDIAN
//  param). The FSM and word counter stay in instruction_loader.
// TESTING
//  1 Reset: rst=0 mid-stream -> all outputs 0 in the same cycle; after release state=IDLE,
//    no write occurs.
//  2 Start, bytes 00 22 18 20 (BIG_ENDIAN=1) -> one write, addr=0, data=32'h00221820;
//    then FF FF FF FF -> write addr=1 data=FFFFFFFF, o_done=1, o_overflow=0.
//  3 BIG_ENDIAN=0, bytes 20 18 22 00 -> data=32'h00221820 at addr 0.
//  4 32 non-HALT words -> writes at addr 0..31, then o_done=1 and o_overflow=1; extra bytes
//    produce no write.
//  5 i_rx_valid every cycle, including the WRITE cycle -> 3 words written correctly,
//    no byte lost, o_wr_instruction high exactly 1 cycle per word.
//  6 i_start pulsed during LOAD -> ignored, counters unchanged; i_start in DONE -> reload
//    from addr 0, o_overflow cleared.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared constants for the instruction loader
// Purpose : FSM state encodings, instruction width and default end-of-program marker.
// Ports   : none (package).
package instruction_loader_pkg;

    localparam int          INSTR_W           = 32;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// rtl/instruction_loader_byte_packer.sv - packs four bytes into one 32-bit word
// Purpose : byte assembly register plus 2-bit byte counter.
// Ports   : clk, rst (async active-low), i_clear (restart packing), i_valid/i_data (byte in),
//           o_word (assembled word including the current byte), o_last (current byte is byte 3).
module instruction_loader_byte_packer
    import instruction_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [7:0]         i_data,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_last
);

    logic [INSTR_W-1:0] r_shift;
    logic [1:0]         r_cnt;

    // Big endian shifts left so the first byte ends in [31:24]; little endian shifts
    // right so the first byte ends in [7:0].
    assign o_word = BIG_ENDIAN ? {r_shift[23:0], i_data} : {i_data, r_shift[31:8]};
    assign o_last = i_valid && (r_cnt == 2'd3);

    // The counter wraps 3 -> 0 on the last byte, so a byte arriving in the following
    // cycle is already byte 0 of the next word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (i_valid) begin
            r_shift <= o_word;
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte stream to instruction memory debug-write port
// Purpose : packs UART bytes into 32-bit words and writes them to consecutive word
//           addresses from 0 until HALT_WORD has been written or memory is full.
// Ports   : clk, rst (async active-low), i_start, i_rx_data/i_rx_valid (byte stream),
//           o_wr_instruction/o_addr/o_data_instruction (memory write port),
//           o_busy, o_done, o_overflow (status).
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int          ADDR_W     = 5,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_wr_instruction,
    output logic [31:0]        o_addr,
    output logic [INSTR_W-1:0] o_data_instruction,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_word_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_data;
    logic               r_wr;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;

    logic               w_accept;
    logic               w_clear;
    logic [INSTR_W-1:0] w_word;
    logic               w_last;

    // Bytes are taken in WRITE too, so a continuous stream never loses a byte.
    assign w_accept = i_rx_valid && ((r_state == ST_LOAD) || (r_state == ST_WRITE));
    assign w_clear  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    instruction_loader_byte_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_valid (w_accept),
        .i_data  (i_rx_data),
        .o_word  (w_word),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state    <= ST_LOAD;
                        r_word_cnt <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_last) begin
                        r_state <= ST_WRITE;
                        r_data  <= w_word;
                        r_addr  <= r_word_cnt;
                        r_wr    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_wr <= 1'b0;
                    if (r_data == HALT_WORD) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_word_cnt == LAST_ADDR) begin
                        // Counter holds at the last address; it never wraps.
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= 1'b1;
                    end else begin
                        r_state    <= ST_LOAD;
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_wr    <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_instruction   = r_wr;
    assign o_addr             = {{(32-ADDR_W){1'b0}}, r_addr};
    assign o_data_instruction = r_data;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_overflow         = r_overflow;

endmodule
